// File: rtl/unique_draw_sequencer_pkg.sv
// Shared types and constants for the unique draw sequencer.
package unique_draw_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_PROBE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Bits needed to count 0..value-1; at least 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while (w < 31 && (32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/unique_draw_sequencer_lfsr_galois.sv
// Free-running right-shift Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up at zero.
module lfsr_galois
  import unique_draw_sequencer_pkg::*;
#(
  parameter int                 LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS_16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

  always_ff @(posedge clk) begin
    if (rst)       q <= SEED_NZ;
    else if (q[0]) q <= (q >> 1) ^ TAPS;
    else           q <= q >> 1;
  end

endmodule

// File: rtl/unique_draw_sequencer.sv
// Paced non-repeating random draw over 0..2^VAL_W-1, one value per PERIOD.
// Build option UNIQUE_PROBE_EN: resolve collisions by linear probing (bounded latency).
module unique_draw_sequencer
  import unique_draw_sequencer_pkg::*;
#(
  parameter int                 VAL_W        = 3,
  parameter int                 PERIOD       = 50_000_000,
  parameter int                 LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter bit                 AUTO_RESTART = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic [VAL_W-1:0] value,
  output logic             value_valid,
  output logic [VAL_W:0]   draw_cnt,
  output logic             all_drawn,
  output logic             busy
);

  localparam int                 N          = 1 << VAL_W;
  localparam logic [VAL_W:0]     N_CNT      = (VAL_W+1)'(N);
  localparam int                 TIMER_W    = clog2(PERIOD);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD - 1);

  state_t             state;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [N-1:0]       mask;
  logic [TIMER_W-1:0] timer;
  logic [VAL_W-1:0]   cand;
  logic [VAL_W-1:0]   slot;
  logic [VAL_W:0]     cnt_inc;
  logic               unused_lfsr_hi;

  lfsr_galois #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED),
    .TAPS   (LFSR_W'(LFSR_TAPS_16))
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign cand           = lfsr_q[VAL_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:VAL_W];
  assign cnt_inc        = draw_cnt + (VAL_W+1)'(1);

`ifdef UNIQUE_PROBE_EN
  logic [VAL_W-1:0] probe_ptr;
  assign slot = (state == ST_PROBE) ? probe_ptr : cand;
`else
  assign slot = cand;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mask        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      draw_cnt    <= '0;
      all_drawn   <= 1'b0;
      busy        <= 1'b0;
      timer       <= '0;
`ifdef UNIQUE_PROBE_EN
      probe_ptr   <= '0;
`endif
    end else begin
      value_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask     <= '0;
            draw_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_DRAW;
          end
        end
`ifdef UNIQUE_PROBE_EN
        ST_DRAW, ST_PROBE: begin
`else
        ST_DRAW: begin
`endif
          if (!mask[slot]) begin
            mask[slot]  <= 1'b1;
            value       <= slot;
            value_valid <= 1'b1;
            draw_cnt    <= cnt_inc;
            timer       <= '0;
            if (cnt_inc == N_CNT) begin
              all_drawn <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end
`ifdef UNIQUE_PROBE_EN
          // cand is already known to be used, so probing starts one slot past it
          else if (state == ST_DRAW) begin
            probe_ptr <= cand + VAL_W'(1);
            state     <= ST_PROBE;
          end else begin
            probe_ptr <= probe_ptr + VAL_W'(1);
          end
`endif
        end
        ST_WAIT: begin
          if (!pause) begin
            if (timer == TIMER_LAST) state <= ST_DRAW;
            else                     timer <= timer + TIMER_W'(1);
          end
        end
        ST_DONE: begin
          if (AUTO_RESTART || start) begin
            mask      <= '0;
            draw_cnt  <= '0;
            all_drawn <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_DRAW;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mask      <= '0;
          value     <= '0;
          draw_cnt  <= '0;
          all_drawn <= 1'b0;
          busy      <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unique_draw_sequencer.sv
// Scoreboard bench: a reference LFSR predicts each round's values and spacing.
module tb_unique_draw_sequencer;

  localparam int          PERIOD = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] value;
  logic       value_valid;
  logic [3:0] draw_cnt;
  logic       all_drawn;
  logic       busy;

  logic       start_ar = 1'b0;
  logic       pause_ar = 1'b0;
  logic [1:0] value_ar;
  logic       valid_ar;
  logic [2:0] cnt_ar;
  logic       all_drawn_ar;
  logic       busy_ar;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic        prev_vv = 1'b0;
  logic [15:0] m_lfsr;
  int          exp_val[$];
  int          exp_gap[$];

  unique_draw_sequencer #(
    .VAL_W(3), .PERIOD(PERIOD), .LFSR_W(16), .SEED(SEED), .AUTO_RESTART(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .value(value), .value_valid(value_valid), .draw_cnt(draw_cnt),
    .all_drawn(all_drawn), .busy(busy)
  );

  unique_draw_sequencer #(
    .VAL_W(2), .PERIOD(PERIOD), .LFSR_W(16), .SEED(SEED), .AUTO_RESTART(1'b1)
  ) dut_ar (
    .clk(clk), .rst(rst), .start(start_ar), .pause(pause_ar),
    .value(value_ar), .value_valid(valid_ar), .draw_cnt(cnt_ar),
    .all_drawn(all_drawn_ar), .busy(busy_ar)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n     = {s[0], s[15:1]};
    n[13] = s[14] ^ s[0];
    n[12] = s[13] ^ s[0];
    n[10] = s[11] ^ s[0];
    return n;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? SEED : ref_step(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (value_valid) check_eq("no_b2b", prev_vv, 0);
    prev_vv <= value_valid;
  end

  // l0 is the LFSR value seen at the edge that samples start.
  task automatic predict_round(input logic [15:0] l0, input int pause_k, input int pause_len);
    logic [7:0]  used;
    logic [15:0] l;
    logic [2:0]  slot;
    int          t, last, w;
    used = '0; l = l0; t = 1; last = 0;
    for (int k = 0; k < 8; k++) begin
      t++; l = ref_step(l); slot = l[2:0];
      if (used[slot]) begin
`ifdef UNIQUE_PROBE_EN
        slot = slot + 3'd1; t++; l = ref_step(l);
        while (used[slot]) begin slot = slot + 3'd1; t++; l = ref_step(l); end
`else
        while (used[l[2:0]]) begin t++; l = ref_step(l); end
        slot = l[2:0];
`endif
      end
      used[slot] = 1'b1;
      exp_val.push_back(int'(slot));
      exp_gap.push_back(t - last);
      last = t;
      if (k < 7) begin
        w = PERIOD + ((k == pause_k) ? pause_len : 0);
        repeat (w) l = ref_step(l);
        t += w;
      end
    end
  endtask

  task automatic expect_draw(input int k);
    int waited, v, g;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!value_valid && waited < 300);
    v = (exp_val.size() > 0) ? exp_val.pop_front() : -1;
    g = (exp_gap.size() > 0) ? exp_gap.pop_front() : -1;
    check_eq("pulse_seen", value_valid, 1);
    check_eq("value", value, v);
    check_eq("gap", cyc - last_cyc, g);
    check_eq("draw_cnt", draw_cnt, k + 1);
`ifdef UNIQUE_PROBE_EN
    if (k == 7) check_eq("probe_bound", (cyc - last_cyc) <= PERIOD + 8, 1);
`endif
    if (k < 7) check_eq("busy_mid", busy, 1);
    last_cyc = cyc;
  endtask

  // Starts a round and checks n_draws pulses; optional pause after draw pause_k.
  task automatic run_round(input int pause_k, input int pause_len, input int n_draws);
    exp_val.delete();
    exp_gap.delete();
    predict_round(m_lfsr, pause_k, pause_len);
    start = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n_draws; k++) begin
      expect_draw(k);
      if (k == pause_k) begin
        pause = 1'b1;
        repeat (pause_len) @(negedge clk);
        pause = 1'b0;
      end
    end
  endtask

  task automatic check_done(input int last_v);
    int pulses;
    check_eq("done_cnt", draw_cnt, 8);
    check_eq("done_all", all_drawn, 1);
    check_eq("done_busy", busy, 0);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (value_valid) pulses++;
    end
    check_eq("quiet_after", pulses, 0);
    check_eq("value_held", value, last_v);
    check_eq("still_done", all_drawn, 1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_value", value, 0);
    check_eq("rst_valid", value_valid, 0);
    check_eq("rst_cnt", draw_cnt, 0);
    check_eq("rst_all", all_drawn, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  initial begin
    int pool[$];
    int idx, waited, last_v;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    check_eq("rst_ar_cnt", cnt_ar, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Round from IDLE, no pause.
    run_round(-1, 0, 8);
    check_done(value);

    // Round from DONE with a 10-cycle pause after the third draw.
    run_round(2, 10, 8);
    last_v = value;
    check_done(last_v);

    // Reset between the 3rd and 4th draw, then a fresh full round.
    run_round(-1, 0, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_round(-1, 0, 8);
    check_done(value);

    // Auto-restart instance: two back-to-back permutations of 0..3 from one start.
    start_ar = 1'b1;
    @(negedge clk);
    start_ar = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pool.delete();
      for (int v = 0; v < 4; v++) pool.push_back(v);
      for (int k = 0; k < 4; k++) begin
        waited = 0;
        do begin @(negedge clk); waited++; end while (!valid_ar && waited < 300);
        check_eq("ar_seen", valid_ar, 1);
        idx = -1;
        foreach (pool[i]) if (pool[i] == int'(value_ar)) idx = i;
        check_eq("ar_unique", idx >= 0, 1);
        if (idx >= 0) pool.delete(idx);
        check_eq("ar_cnt", cnt_ar, k + 1);
      end
      check_eq("ar_all_hi", all_drawn_ar, 1);
      @(negedge clk);
      check_eq("ar_all_lo", all_drawn_ar, 0);
      check_eq("ar_busy", busy_ar, 1);
      check_eq("ar_cnt_clr", cnt_ar, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unique_draw_sequencer.md
Name: unique_draw_sequencer

Overview:
Parametrised generator of a paced, non-repeating random sequence over 0..2^VAL_W-1. It combines a free-running Galois LFSR, a used-value mask, a period timer and a draw FSM into one block. It emits one new unique value per period until all values are drawn, then stops or auto-restarts. It feeds the display/trigger logic of the game top level and supersedes the fixed 3-bit, 1-second, single-round arrangement.

Parameters:
VAL_W, 3, value width; N = 2^VAL_W values per round (1..6 supported)
PERIOD, 50_000_000, clock cycles between successive draws (>= 1)
LFSR_W, 16, LFSR width (must be >= VAL_W; only 16 supported with default taps)
SEED, 16'hACE1, LFSR reset value; a zero seed is replaced by 1
AUTO_RESTART, 0, 1 = begin a new round automatically after the round completes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a round; sampled only in IDLE or DONE
pause  in  1  freezes the period timer while high (WAIT only)
value  out  VAL_W  most recently drawn value; held between draws
value_valid  out  1  one-cycle pulse, asserted with each new value
draw_cnt  out  VAL_W+1  number of values drawn this round (0..N)
all_drawn  out  1  high while in DONE
busy  out  1  high in DRAW, PROBE and WAIT

Behaviour:
- Reset (rst wins over everything): state=IDLE, lfsr=SEED (or 1 if SEED==0), mask=0, value=0, value_valid=0, draw_cnt=0, all_drawn=0, busy=0, timer=0.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle after reset, in every state. Never reaches zero. cand = lfsr[VAL_W-1:0].
- IDLE: start=1 -> mask=0, draw_cnt=0, go to DRAW.
- DRAW: evaluated every cycle.
  - mask[cand]==0 (hit): set mask[cand]; value<=cand; value_valid=1 next cycle; draw_cnt<=draw_cnt+1.
    - If the new draw_cnt==N -> DONE; else -> WAIT with timer=0.
  - mask[cand]==1 (collision): stay in DRAW and retry on the next LFSR value (without PROBE_EN).
- WAIT: timer increments per cycle unless pause=1 (pause holds the count). When timer==PERIOD-1 and pause==0 -> DRAW.
  - First draw latency: 1 cycle after start plus collision retries. Inter-draw spacing: PERIOD+1 cycles plus retries and paused cycles.
- DONE: all_drawn=1, busy=0, value holds the last value.
  - AUTO_RESTART=1: the next cycle clears mask and draw_cnt and goes to DRAW; all_drawn drops.
  - AUTO_RESTART=0: holds until start=1, then clears and goes to DRAW.
- start outside IDLE/DONE is ignored. pause outside WAIT has no effect.
- value_valid never asserts on two consecutive cycles when PERIOD>=1.
- Illegal state encoding -> IDLE, all outputs return to reset values except the LFSR.
- Width rule: draw_cnt compares against N as a VAL_W+1-bit constant; no overflow at N.

Optional Feature:
Macro UNIQUE_PROBE_EN.
- Defined: on a collision in DRAW, latch cand into probe_ptr and enter PROBE. Each cycle probe_ptr <= (probe_ptr+1) mod N until an unused slot is found; that slot is drawn exactly as a DRAW hit. Worst-case draw latency is bounded to N cycles.
- Undefined: no PROBE state; retry in DRAW indefinitely on LFSR values (latency unbounded in theory, statistically finite).

Decomposition:
- Shared package: FSM state typedef (IDLE, DRAW, PROBE, WAIT, DONE), default LFSR tap mask constant, and the timer width function clog2(PERIOD).
- One sub-module: lfsr_galois (params LFSR_W, SEED, TAPS; ports clk, rst, q).
- Mask, FSM and timer stay in the top module.

Test Plan:
- Reset with defaults, PERIOD=4, start pulse -> exactly 8 value_valid pulses; values form a permutation of 0..7; draw_cnt ends at 8; all_drawn=1; no further pulses for 100 cycles.
- Same bench, measure gaps between value_valid pulses -> each >= 5 cycles; gap == 5 when no collision.
- PERIOD=4, pause held 10 cycles mid-WAIT -> gap to the next pulse grows by exactly 10.
- AUTO_RESTART=1, VAL_W=2 -> after 4 draws all_drawn pulses for 1 cycle, then a second permutation of 0..3 follows without start.
- rst asserted between the 3rd and 4th draw -> all outputs at reset values next cycle; a fresh start yields a full 8-value permutation.
- UNIQUE_PROBE_EN defined, VAL_W=3, force collision (mask 7 slots) -> last value is drawn within <= 8 cycles of entering DRAW.
